grid_bank_server: RTL

//  Memory-side responder for the freemachine row/chunk protocol. It holds one grid bank of DEPTH rows x VEC_W bits.
//  It serves level-held read/write requests addressed by (row, col) in DATA_W-bit chunks, and answers each one with an ack pulse.
//  A host load port fills the bank before a run. One instance sits per bank, between the input parser and its freemachine.

---
 rtl/grid_bank_server_pkg.sv | 11 +
 rtl/grid_bank_server_mem.sv | 33 +++
 rtl/grid_bank_server.sv | 106 ++++++++++
 3 files changed

// File: rtl/grid_bank_server_pkg.sv
// grid_bank_server_pkg: shared defaults, FSM state type and chunk helper for grid_bank_server
package grid_bank_server_pkg;
  localparam int DATA_W = 32;
  localparam int VEC_W = 160;
  localparam int DEPTH = 140;
  localparam int chunks_per_row = VEC_W / DATA_W;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, ACK} bank_state_t;
  function automatic int unsigned chunk_idx(input int unsigned col, input int unsigned dw = DATA_W);
    return col / dw;
  endfunction
endpackage

// File: rtl/grid_bank_server_mem.sv
// grid_bank_server_mem: 2-write/1-read RAM, load port wins on same-word conflict, registered read
//   clock, reset              : clock, sync active-high reset (read register only)
//   load_en/addr/data         : host write port
//   write_en/addr/data        : requester write port
//   read_en/addr, read_data   : registered read port
module grid_bank_server_mem import grid_bank_server_pkg::*; #(
  parameter int DATA_W = grid_bank_server_pkg::DATA_W,
  parameter int WORDS = 700,
  localparam int AW = $clog2(WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              write_en,
  input  logic [AW-1:0]     write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [AW-1:0]     read_addr,
  output logic [DATA_W-1:0] read_data
);
  logic [DATA_W-1:0] mem [WORDS];
  // the load write is scheduled last so it overrides a requester write to the same word
  always_ff @(posedge clock) begin
    if (write_en) mem[write_addr] <= write_data;
    if (load_en) mem[load_addr] <= load_data;
  end
  always_ff @(posedge clock) begin
    if (reset) read_data <= '0;
    else if (read_en) read_data <= mem[read_addr];
  end
endmodule

// File: rtl/grid_bank_server.sv
// grid_bank_server: row/chunk request responder for one grid bank with host load port
//   clock, reset                          : clock, sync active-high reset
//   load_valid/row/col/data               : host chunk load, always accepted
//   read_en, write_en, row_addr, col_addr, wdata : level-held requester access
//   ack_out, rdata_out                    : one-cycle response pulse and read data
//   busy_out, proto_err_out, access_cnt   : in-flight flag, sticky error, saturating ack count
//   GRID_BANK_OOB_ONES_EN                 : when defined, reads past the last row return all-ones
module grid_bank_server import grid_bank_server_pkg::*; #(
  parameter int DEPTH = grid_bank_server_pkg::DEPTH,
  parameter int VEC_W = grid_bank_server_pkg::VEC_W,
  parameter int DATA_W = grid_bank_server_pkg::DATA_W,
  parameter int RD_LAT = 2,
  localparam int RW = $clog2(DEPTH + 1),
  localparam int CW = $clog2(VEC_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [RW-1:0]     load_row,
  input  logic [CW-1:0]     load_col,
  input  logic [DATA_W-1:0] load_data,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [RW-1:0]     row_addr,
  input  logic [CW-1:0]     col_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              busy_out,
  output logic              proto_err_out,
  output logic [31:0]       access_cnt
);
  localparam int CPR = VEC_W / DATA_W;
  localparam int WORDS = DEPTH * CPR;
  localparam int AW = $clog2(WORDS);
  localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
`ifdef GRID_BANK_OOB_ONES_EN
  localparam logic [DATA_W-1:0] OOB_FILL = '1;
`else
  localparam logic [DATA_W-1:0] OOB_FILL = '0;
`endif
  bank_state_t state, next;
  logic [RW-1:0] req_row;
  logic [CW-1:0] req_col;
  logic [DATA_W-1:0] req_wdata, mem_q;
  logic [LW-1:0] cnt;
  logic [AW-1:0] req_addr, load_addr;
  logic capture, row_ok, col_ok, load_ok, mem_we, mem_re;
  function automatic logic col_fine(input logic [CW-1:0] c);
    return (int'(c) % DATA_W) == 0 && int'(c) < VEC_W;
  endfunction
  assign capture = state == IDLE && !load_valid && (read_en || write_en);
  assign row_ok = int'(req_row) < DEPTH;
  assign col_ok = col_fine(req_col);
  assign load_ok = load_valid && int'(load_row) < DEPTH && col_fine(load_col);
  assign req_addr = AW'(32'(req_row) * CPR + chunk_idx(32'(req_col), DATA_W));
  assign load_addr = AW'(32'(load_row) * CPR + chunk_idx(32'(load_col), DATA_W));
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state == IDLE ? (capture ? (write_en ? WR : RD_WAIT) : IDLE)
         : state == RD_WAIT ? (cnt == LW'(RD_LAT - 1) ? ACK : RD_WAIT)
         : state == WR ? ACK : IDLE;
  end
  // the read is issued on the first RD_WAIT cycle, so a load landing in that same cycle is not seen
  always_comb begin
    busy_out = state == RD_WAIT || state == WR;
    ack_out = state == ACK;
    mem_re = state == RD_WAIT && cnt == '0 && row_ok && col_ok;
    mem_we = state == WR && row_ok && col_ok && !reset;
    rdata_out = !ack_out || !col_ok ? '0 : row_ok ? mem_q : OOB_FILL;
  end
  always_ff @(posedge clock) begin
    if (capture) begin
      req_row <= row_addr;
      req_col <= col_addr;
      req_wdata <= wdata;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      proto_err_out <= 1'b0;
      access_cnt <= '0;
    end else begin
      cnt <= state == RD_WAIT ? cnt + 1'b1 : '0;
      if (capture && ((read_en && write_en) || !col_fine(col_addr))) proto_err_out <= 1'b1;
      if (state == ACK && access_cnt != '1) access_cnt <= access_cnt + 1'b1;
    end
  end
  grid_bank_server_mem #(.DATA_W(DATA_W), .WORDS(WORDS)) u_mem (
    .clock(clock),
    .reset(reset),
    .load_en(load_ok),
    .load_addr(load_addr),
    .load_data(load_data),
    .write_en(mem_we),
    .write_addr(req_addr),
    .write_data(req_wdata),
    .read_en(mem_re),
    .read_addr(req_addr),
    .read_data(mem_q)
  );
endmodule
